// File: rtl/cycle_sequencer_pkg.sv
// Shared control-unit definitions: T-step one-hot codes, sequencer state encoding,
// one-hot decode field widths and the opcode value loaded at reset.
package cycle_sequencer_pkg;

  localparam logic [3:0] T1 = 4'b0001;
  localparam logic [3:0] T2 = 4'b0010;
  localparam logic [3:0] T3 = 4'b0100;
  localparam logic [3:0] T4 = 4'b1000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

  localparam int X_W = 4;
  localparam int Y_W = 8;
  localparam int Z_W = 8;
  localparam int P_W = 4;
  localparam int Q_W = 2;

  // NOP: the core starts by executing a harmless opcode until the first real fetch.
  localparam logic [7:0] DEFAULT_RESET_OPCODE = 8'h00;

endpackage

// File: rtl/opcode_field_decode.sv
// Splits an 8-bit opcode into one-hot X/Y/Z/P/Q fields; purely combinational, no
// storage and no flow control. Shared by the sequencer and the CB slice.
module opcode_field_decode
  import cycle_sequencer_pkg::*;
(
  input  logic [7:0]     i_Opcode,
  output logic [X_W-1:0] o_X,
  output logic [Y_W-1:0] o_Y,
  output logic [Z_W-1:0] o_Z,
  output logic [P_W-1:0] o_P,
  output logic [Q_W-1:0] o_Q
);

  always_comb begin
    o_X = '0;
    o_Y = '0;
    o_Z = '0;
    o_P = '0;
    o_Q = '0;
    o_X[i_Opcode[7:6]] = 1'b1;
    o_Y[i_Opcode[5:3]] = 1'b1;
    o_Z[i_Opcode[2:0]] = 1'b1;
    o_P[i_Opcode[5:4]] = 1'b1;
    o_Q[i_Opcode[3]]   = 1'b1;
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Control-unit timing engine: one-hot T-step / M-cycle counters, opcode latch, IME and CB mode.
// Requests act only on the non-stalled T4 edge; i_Wait freezes everything; outputs are registered.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int         COUNT_W      = 8,
  parameter logic [7:0] RESET_OPCODE = DEFAULT_RESET_OPCODE
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Wait,
  input  logic [7:0]         i_Data_Bus,
  input  logic               i_Fetch,
  input  logic               i_Reset_Cycle,
  input  logic               i_EI,
  input  logic               i_DI,
  input  logic               i_CB_Prefix,
  output logic [3:0]         o_Cycle_Step,
  output logic [COUNT_W-1:0] o_Cycle_Count,
  output logic               o_Active,
  output logic               o_Fetch_Cycle,
  output logic [7:0]         o_Opcode,
  output logic [X_W-1:0]     o_X,
  output logic [Y_W-1:0]     o_Y,
  output logic [Z_W-1:0]     o_Z,
  output logic [P_W-1:0]     o_P,
  output logic [Q_W-1:0]     o_Q,
  output logic               o_CB,
  output logic               o_IME,
  output logic               o_Seq_Error
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_step;
  logic [3:0]         w_step_nxt;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_nxt;
  logic [7:0]         r_opcode;
  logic               r_cb;
  logic               r_cb_pend;
  logic               r_ime;
  logic               r_ei_pend;
  logic               r_ei_arm;
  logic               r_seq_error;

  logic               w_t4;
  logic               w_exec_t4;
  logic               w_latch;
  logic               w_overflow;
  logic               w_cb_req;

  assign w_t4      = (r_step == T4) && !i_Wait;
  assign w_exec_t4 = w_t4 && (r_state == ST_EXEC);
  assign w_cb_req  = w_exec_t4 && i_CB_Prefix;

  always_comb begin
    w_step_nxt = r_step;
    if (!i_Wait) begin
      case (r_step)
        T1:      w_step_nxt = T2;
        T2:      w_step_nxt = T3;
        T3:      w_step_nxt = T4;
        default: w_step_nxt = T1;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state, M-cycle counter and latch strobe; Reset_Cycle outranks Fetch
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_latch     = 1'b0;
    w_overflow  = 1'b0;
    if (w_t4) begin
      if (r_state == ST_FETCH) begin
        w_latch     = 1'b1;
        w_count_nxt = COUNT_W'(1);
        w_state_nxt = ST_EXEC;
      end else if (i_Reset_Cycle) begin
        w_count_nxt = COUNT_W'(1);
        w_state_nxt = ST_FETCH;
      end else if (i_Fetch) begin
        w_latch     = 1'b1;
        w_count_nxt = COUNT_W'(1);
      end else if (r_count[COUNT_W-1]) begin
        w_overflow  = 1'b1;
        w_count_nxt = COUNT_W'(1);
        w_state_nxt = ST_FETCH;
      end else begin
        w_count_nxt = r_count << 1;
      end
    end
  end

  // FSM: state-decoded outputs
  always_comb begin
    o_Active      = 1'b0;
    o_Fetch_Cycle = 1'b0;
    case (r_state)
      ST_FETCH: o_Fetch_Cycle = 1'b1;
      ST_EXEC:  o_Active      = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_step      <= T1;
      r_count     <= COUNT_W'(1);
      r_opcode    <= RESET_OPCODE;
      r_cb        <= 1'b0;
      r_cb_pend   <= 1'b0;
      r_seq_error <= 1'b0;
    end else begin
      r_step  <= w_step_nxt;
      r_count <= w_count_nxt;
      // A prefix raised on the same T4 as the overlapped fetch applies to that fetch.
      if (w_latch) begin
        r_opcode  <= i_Data_Bus;
        r_cb      <= r_cb_pend | w_cb_req;
        r_cb_pend <= 1'b0;
      end else if (w_cb_req) begin
        r_cb_pend <= 1'b1;
      end
      if (w_overflow) begin
        r_seq_error <= 1'b1;
      end
    end
  end

  // EI takes effect one instruction late: pend -> arm (successor latched) -> IME on the next latch.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_ime     <= 1'b0;
      r_ei_pend <= 1'b0;
      r_ei_arm  <= 1'b0;
    end else if (w_exec_t4 && i_DI) begin
      r_ime     <= 1'b0;
      r_ei_pend <= 1'b0;
      r_ei_arm  <= 1'b0;
    end else begin
      if (w_latch && r_ei_arm) begin
        r_ime    <= 1'b1;
        r_ei_arm <= 1'b0;
      end
      if (w_latch && r_ei_pend) begin
        r_ei_arm  <= 1'b1;
        r_ei_pend <= 1'b0;
      end
      if (w_exec_t4 && i_EI) begin
        if (w_latch) begin
          r_ei_arm <= 1'b1;
        end else begin
          r_ei_pend <= 1'b1;
        end
      end
    end
  end

  opcode_field_decode u_field_decode (
    .i_Opcode (r_opcode),
    .o_X      (o_X),
    .o_Y      (o_Y),
    .o_Z      (o_Z),
    .o_P      (o_P),
    .o_Q      (o_Q)
  );

  assign o_Cycle_Step  = r_step;
  assign o_Cycle_Count = r_count;
  assign o_Opcode      = r_opcode;
  assign o_CB          = r_cb;
  assign o_IME         = r_ime;
  assign o_Seq_Error   = r_seq_error;

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Timing and opcode-latch engine of the control unit; the counterpart to the decode slices (X0..X3, CB).
- Generates T-step and M-cycle counters and latches the opcode. Produces the one-hot X/Y/Z/P/Q fields and the Active qualifier.
- Consumes the slices' Fetch, Reset_Cycle, EI, DI and CB_Prefix requests. Owns IME and the CB-prefix mode bit.

Parameters:
- COUNT_W, 8, width of one-hot M-cycle counter (o_Cycle_Count).
- RESET_OPCODE, 8'h00, opcode register value after reset (NOP).

Ports:
- i_Clk  in  1  system clock, rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Wait  in  1  stall: freezes step, count and state while high.
- i_Data_Bus  in  8  data bus; opcode source at fetch latch.
- i_Fetch  in  1  OR of slice o_Fetch: overlap-fetch request.
- i_Reset_Cycle  in  1  OR of slice o_Reset_Cycle: enter dedicated fetch M-cycle.
- i_EI  in  1  enable-interrupt request.
- i_DI  in  1  disable-interrupt request.
- i_CB_Prefix  in  1  next opcode is CB-page.
- o_Cycle_Step  out  4  one-hot T-state; bit3 = T4.
- o_Cycle_Count  out  COUNT_W  one-hot M-cycle index of current instruction.
- o_Active  out  1  high in EXEC state.
- o_Fetch_Cycle  out  1  high in FETCH state; drives PC address-out and increment.
- o_Opcode  out  8  latched opcode.
- o_X  out  4  one-hot opcode[7:6].
- o_Y  out  8  one-hot opcode[5:3].
- o_Z  out  8  one-hot opcode[2:0].
- o_P  out  4  one-hot opcode[5:4].
- o_Q  out  2  one-hot opcode[3].
- o_CB  out  1  current opcode is CB-page.
- o_IME  out  1  interrupt master enable.
- o_Seq_Error  out  1  sticky: M-cycle counter overflow.

Behaviour:
- Reset (async):
  - Step 4'b0001, Count 1, state FETCH, opcode RESET_OPCODE, CB 0.
  - IME 0, EI-pending 0, Seq_Error 0.
  - o_Active 0, o_Fetch_Cycle 1.
  - Reset mid-instruction aborts immediately.
- Step rotation: left-rotates each clock unless i_Wait. A held i_Wait freezes all registers; requests are sampled only on the non-waiting T4 edge.
- Requests are acted on only at the T4 edge (Step[3] & !i_Wait). Outside T4 they are ignored.
- FETCH state, at T4:
  - Latch opcode <- i_Data_Bus; CB <- CB-pending; clear CB-pending.
  - Count <- 1; go EXEC.
  - Slices are inactive in FETCH, so their requests are not acted on.
- EXEC state, at T4, in priority order:
  - i_Reset_Cycle: go FETCH, Count <- 1, opcode held. Wins over a simultaneous i_Fetch.
  - Else i_Fetch (overlapped fetch): opcode <- i_Data_Bus, CB <- CB-pending, clear CB-pending, Count <- 1, stay EXEC.
  - Else Count shifts left one place.
  - If Count[COUNT_W-1] was set: no shift. Seq_Error <- 1, go FETCH, Count <- 1.
- Decode fields are combinational from the opcode register. They are valid the cycle after the latch and stable for the whole instruction.
- CB-pending: set by i_CB_Prefix at T4; consumed by the next opcode latch. After the CB-page opcode executes, CB returns to 0 on the following latch.
- Interrupt enable:
  - i_DI at T4: IME <- 0 and EI-pending <- 0, effective next cycle.
  - i_EI at T4: EI-pending <- 1.
  - IME <- 1 at the T4 of the instruction following EI, i.e. the next opcode-latch T4 after the one that latched EI's successor.
  - i_EI and i_DI together: DI wins.
- No combinational path from request inputs to any output.

Decomposition:
- Shared control-unit package holds:
  - T-step one-hot constants (T1..T4).
  - State encoding FETCH/EXEC.
  - Field widths (X=4, Y/Z=8, P=4, Q=2).
  - RESET_OPCODE.
- One sub-module: opcode_field_decode. Pure combinational, 8-bit opcode in, one-hot X/Y/Z/P/Q out; reused by the CB slice.

Test Plan:
- Reset, then free-run with i_Data_Bus=8'h00 -> Step walks 0001,0010,0100,1000. At the first T4 go EXEC with o_Opcode=00, o_Z=8'h01, o_X=4'h1, o_Active=1 from the next cycle.
- In EXEC, drive i_Fetch at T4 with bus=8'hC3 -> Count=1, o_Opcode=C3, o_Y=8'h01, o_Z=8'h08, o_X=4'h8, state stays EXEC. Hold i_Fetch low for 3 T4s -> Count 02,04,08.
- At one T4 assert i_Reset_Cycle and i_Fetch together with bus=8'h77 -> o_Fetch_Cycle=1, opcode unchanged. At the next T4 with bus=8'h3E -> opcode=3E, EXEC.
- i_CB_Prefix with i_Fetch at T4, bus=8'h37 -> o_CB=1, opcode 37. The next fetch, bus=8'h00 -> o_CB=0.
- EI at T4, then the following instruction's T4 -> IME stays 0 until that T4, then 1. EI+DI together -> IME stays 0. Also hold i_Wait for 5 cycles mid-M-cycle -> Step and Count frozen.
- 8 T4s in EXEC without fetch -> o_Seq_Error=1, FETCH entered. Async reset pulse mid-T2 -> all reset values within the same cycle.
